control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter ITERS, default 8, number of bit-scan iterations per run; legal range 1..8.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 start  input  1  request to begin a run; sampled only in IDLE.
REQ-005 b  input  1  datapath status, current bit y[s].
REQ-006 y_inc  input  1  datapath status, high when s+1 == 3.
REQ-007 y_select_next  output  2  datapath y source: 0 hold, 1 y+1, 2 y+s, 3 y-s.
REQ-008 s_step  output  2  datapath s step amount.
REQ-009 y_en, s_en  output  1 each  datapath register write enables.
REQ-010 y_store_x, s_add, s_zero  output  1 each  datapath mux selects: load x, add step, zero base.
REQ-011 busy  output  1  high from LOAD through the last STEP.
REQ-012 done  output  1  one-cycle pulse marking the end of a run.

Function
REQ-013 The block SHALL be a Moore/Mealy FSM with states IDLE, LOAD, TEST, STEP and DONE, plus an internal iteration counter of at least 4 bits.
REQ-014 Default output values in every state: all enables and selects 0, y_select_next=0, s_step=0.
REQ-015 IDLE: start=1 SHALL go to LOAD; start=0 SHALL stay in IDLE.
REQ-016 LOAD SHALL assert y_store_x=1, y_en=1, s_zero=1, s_add=1, s_step=0 and s_en=1, so that y<=x and s<=0.
REQ-017 LOAD SHALL clear the iteration counter and go to TEST.
REQ-018 TEST, b=1: SHALL assert y_en=1 with y_select_next=2 (y<=y+s).
REQ-019 TEST, b=0 and y_inc=1: SHALL assert y_en=1 with y_select_next=1 (y<=y+1).
REQ-020 TEST, b=0 and y_inc=0: SHALL keep y_en=0.
REQ-021 TEST SHALL always go to STEP.
REQ-022 STEP SHALL assert s_en=1, s_add=1, s_zero=0 and s_step=1 (s<=s+1, 3-bit wrap 7->0).
REQ-023 STEP SHALL increment the iteration counter.
REQ-024 STEP SHALL go to DONE when the counter reaches ITERS, else to TEST.
REQ-025 DONE SHALL assert done=1 for exactly one cycle, with no datapath enables, then go to IDLE.
REQ-026 busy SHALL be 1 in LOAD, TEST and STEP, and 0 in IDLE and DONE.
REQ-027 start SHALL be ignored outside IDLE; start held high through DONE SHALL begin a new run on the first IDLE cycle.
REQ-028 Run latency with ITERS=8: start sampled at edge k gives LOAD in cycle k+1, TEST/STEP alternating in cycles k+2..k+17, and done=1 in cycle k+18.
REQ-029 Datapath arithmetic is 8-bit modulo 256; the controller SHALL NOT special-case overflow.
REQ-030 The y_select_next=3 encoding is reserved and SHALL never be driven in this version.

Reset
REQ-031 rst=0 SHALL immediately, without waiting for a clock, force state IDLE, counter 0, busy=0, done=0 and all datapath controls to their defaults.
REQ-032 Reset asserted mid-run SHALL abort the run with no done pulse; the first run after release SHALL begin only on a fresh start sampled in IDLE.

Verification
REQ-033 Controller driving the datapath, x=8'h00, start pulse -> final y=8'h01 (y+1 at s=2), s=0, done exactly once at cycle k+18.
REQ-034 x=8'hFF -> y: s0 hold FF, s1 y+1 wraps to 00, s2 y_inc gives 01 -> final y=8'h01.
REQ-035 x=8'h04 -> b=1 at s=2 takes priority over y_inc, y=06 -> final y=8'h06.
REQ-036 Start held high continuously -> back-to-back runs separated by exactly one DONE cycle and one IDLE cycle; done pulses are one cycle wide.
REQ-037 rst=0 asserted in the cycle after the 3rd TEST -> outputs at defaults before the next clock edge, no done; after release, IDLE until the next start.
REQ-038 ITERS=1, x=8'h01 -> LOAD, one TEST (y<=01+0), one STEP (s=1), then done at cycle k+4, final y=8'h01.

Source files
------------

// File: rtl/control_unit.sv
// rtl/control_unit.sv - bit-scan run controller for the y/s datapath
//
// Purpose:
//   Sequences one run of ITERS bit-scan iterations over an external
//   datapath holding an 8-bit accumulator y and a 3-bit index s.
//   Each run has these phases:
//     LOAD : y <= x, s <= 0
//     TEST : conditionally update y from b = y[s] and y_inc
//     STEP : s <= s + 1 (3-bit wrap)
//   TEST and STEP alternate ITERS times. A one-cycle DONE follows.
//
// Ports:
//   clk            rising-edge system clock
//   rst            asynchronous active-low reset
//   start          run request, honoured only while idle
//   b              datapath status: current bit y[s]
//   y_inc          datapath status: s+1 == 3
//   y_select_next  y source: 0 hold, 1 y+1, 2 y+s (3 reserved, never driven)
//   s_step         step amount added to s
//   y_en, s_en     datapath register write enables
//   y_store_x      y loads x
//   s_add          s adds s_step
//   s_zero         s base forced to zero
//   busy           high in LOAD, TEST and STEP
//   done           one-cycle end-of-run pulse

module control_unit #(
  parameter int ITERS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       b,
  input  logic       y_inc,
  output logic [1:0] y_select_next,
  output logic [1:0] s_step,
  output logic       y_en,
  output logic       s_en,
  output logic       y_store_x,
  output logic       s_add,
  output logic       s_zero,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_TEST = 3'd2,
    ST_STEP = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [3:0] ITERS_C = 4'(ITERS);

  localparam logic [1:0] SEL_HOLD = 2'd0;
  localparam logic [1:0] SEL_INC  = 2'd1;
  localparam logic [1:0] SEL_ADDS = 2'd2;

  state_t     state_q, state_d;
  logic [3:0] iter_q,  iter_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;

  // Next-state and iteration counter.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        iter_d  = 4'd0;
        state_d = ST_TEST;
      end
      ST_TEST: begin
        state_d = ST_STEP;
      end
      ST_STEP: begin
        iter_d = iter_q + 4'd1;
        // Compare the incremented value so the ITERS-th STEP exits straight to DONE.
        if (iter_d == ITERS_C) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_TEST;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // busy/done are registered from the next state, so each one lines up
  // with the state it describes without any combinational decode.
  always_comb begin
    busy_d = (state_d == ST_LOAD) || (state_d == ST_TEST) || (state_d == ST_STEP);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      iter_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  // Datapath controls are decoded from the current state. TEST must be
  // Mealy: b and y_inc only reflect y[s] once the datapath has settled
  // in that cycle. Because state_q resets asynchronously, every control
  // also returns to its default as soon as rst falls.
  always_comb begin
    y_select_next = SEL_HOLD;
    s_step        = 2'd0;
    y_en          = 1'b0;
    s_en          = 1'b0;
    y_store_x     = 1'b0;
    s_add         = 1'b0;
    s_zero        = 1'b0;
    case (state_q)
      ST_LOAD: begin
        y_store_x = 1'b1;
        y_en      = 1'b1;
        s_zero    = 1'b1;
        s_add     = 1'b1;
        s_step    = 2'd0;
        s_en      = 1'b1;
      end
      ST_TEST: begin
        // The set bit takes priority over the s+1 == 3 increment.
        if (b) begin
          y_en          = 1'b1;
          y_select_next = SEL_ADDS;
        end else if (y_inc) begin
          y_en          = 1'b1;
          y_select_next = SEL_INC;
        end
      end
      ST_STEP: begin
        s_en   = 1'b1;
        s_add  = 1'b1;
        s_zero = 1'b0;
        s_step = 2'd1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit

module tb_control_unit;

  logic clk;
  logic rst;
  int   vec;
  int   errs;

  // ITERS=8 instance and its datapath model
  logic       start8, b8, yinc8;
  logic [1:0] sel8, step8;
  logic       yen8, sen8, ystx8, sadd8, szero8, busy8, done8;
  logic [7:0] x8, y8;
  logic [2:0] s8;

  // ITERS=1 instance and its datapath model
  logic       start1, b1, yinc1;
  logic [1:0] sel1, step1;
  logic       yen1, sen1, ystx1, sadd1, szero1, busy1, done1;
  logic [7:0] x1, y1;
  logic [2:0] s1;

  control_unit #(.ITERS(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .b(b8), .y_inc(yinc8),
    .y_select_next(sel8), .s_step(step8), .y_en(yen8), .s_en(sen8),
    .y_store_x(ystx8), .s_add(sadd8), .s_zero(szero8), .busy(busy8), .done(done8)
  );

  control_unit #(.ITERS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .b(b1), .y_inc(yinc1),
    .y_select_next(sel1), .s_step(step1), .y_en(yen1), .s_en(sen1),
    .y_store_x(ystx1), .s_add(sadd1), .s_zero(szero1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign b8    = y8[s8];
  assign yinc8 = (s8 == 3'd2);
  assign b1    = y1[s1];
  assign yinc1 = (s1 == 3'd2);

  always @(posedge clk) begin
    if (yen8) begin
      if (ystx8) y8 <= x8;
      else case (sel8)
        2'd1: y8 <= y8 + 8'd1;
        2'd2: y8 <= y8 + {5'd0, s8};
        2'd3: y8 <= y8 - {5'd0, s8};
        default: y8 <= y8;
      endcase
    end
    if (sen8) s8 <= (szero8 ? 3'd0 : s8) + (sadd8 ? {1'b0, step8} : 3'd0);
  end

  always @(posedge clk) begin
    if (yen1) begin
      if (ystx1) y1 <= x1;
      else case (sel1)
        2'd1: y1 <= y1 + 8'd1;
        2'd2: y1 <= y1 + {5'd0, s1};
        2'd3: y1 <= y1 - {5'd0, s1};
        default: y1 <= y1;
      endcase
    end
    if (sen1) s1 <= (szero1 ? 3'd0 : s1) + (sadd1 ? {1'b0, step1} : 3'd0);
  end

  task automatic test_reset();
    rst = 1'b0; start8 = 1'b0; start1 = 1'b0; x8 = 8'h00; x1 = 8'h00;
    #2;
    vec++;
    if ({busy8, done8, yen8, sen8, ystx8, sadd8, szero8, step8, sel8} !== 11'd0) begin
      errs++;
      $display("FAIL reset_outputs8 got %b want 0", {busy8, done8, yen8, sen8, ystx8, sadd8, szero8, step8, sel8});
    end
    vec++;
    if ({busy1, done1, yen1, sen1, ystx1, sadd1, szero1, step1, sel1} !== 11'd0) begin
      errs++;
      $display("FAIL reset_outputs1 got %b want 0", {busy1, done1, yen1, sen1, ystx1, sadd1, szero1, step1, sel1});
    end
    // start while reset is held must not begin a run
    start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vec++;
    if (busy8 !== 1'b0 || yen8 !== 1'b0) begin
      errs++;
      $display("FAIL reset_holds_idle busy=%b y_en=%b want 0 0", busy8, yen8);
    end
    start8 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_run8(input logic [7:0] xv, input logic [7:0] yexp,
                         input logic [1:0] sel6_exp, input string nm);
    int done_at, done_cnt, bad_ctl;
    logic [1:0] sel6;
    done_at = -1; done_cnt = 0; bad_ctl = 0; sel6 = 2'd0;
    x8 = xv;
    @(negedge clk); start8 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk); start8 = 1'b0;
      if (c == 1) begin
        vec++;
        if ({busy8, yen8, ystx8, sen8, szero8, sadd8, step8, sel8} !== 10'b111111_00_00) begin
          errs++;
          $display("FAIL %s load_ctl got %b want 1111110000", nm, {busy8, yen8, ystx8, sen8, szero8, sadd8, step8, sel8});
        end
      end
      if (done8) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
        if (yen8 || sen8 || busy8) bad_ctl++;
      end
      if (sel8 == 2'd3) bad_ctl++;
      if (c == 6) sel6 = sel8;
    end
    vec++;
    if (done_at != 18) begin errs++; $display("FAIL %s done_cycle got k+%0d want k+18", nm, done_at); end
    vec++;
    if (done_cnt != 1) begin errs++; $display("FAIL %s done_count got %0d want 1", nm, done_cnt); end
    vec++;
    if (y8 !== yexp) begin errs++; $display("FAIL %s final_y got %h want %h", nm, y8, yexp); end
    vec++;
    if (s8 !== 3'd0) begin errs++; $display("FAIL %s final_s got %0d want 0", nm, s8); end
    vec++;
    if (sel6 !== sel6_exp) begin errs++; $display("FAIL %s test_s2_sel got %0d want %0d", nm, sel6, sel6_exp); end
    vec++;
    if (bad_ctl != 0) begin errs++; $display("FAIL %s bad_controls got %0d want 0", nm, bad_ctl); end
    vec++;
    if (busy8 !== 1'b0) begin errs++; $display("FAIL %s idle_after_done busy=%b want 0", nm, busy8); end
  endtask

  task automatic test_runs();
    do_run8(8'h00, 8'h01, 2'd1, "x00");
    do_run8(8'hFF, 8'h01, 2'd1, "xFF");
    do_run8(8'h04, 8'h06, 2'd2, "x04");
  endtask

  task automatic test_back_to_back();
    int bad, first_bad, waited;
    logic exp_done, exp_busy;
    bad = 0; first_bad = -1;
    x8 = 8'h00;
    @(negedge clk); start8 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      exp_done = (c == 18) || (c == 37);
      exp_busy = !((c == 18) || (c == 19) || (c == 37) || (c == 38));
      if (done8 !== exp_done || busy8 !== exp_busy) begin
        bad++;
        if (first_bad < 0) first_bad = c;
      end
    end
    vec++;
    if (bad != 0) begin
      errs++;
      $display("FAIL back_to_back %0d bad cycles, first at k+%0d, want 0", bad, first_bad);
    end
    start8 = 1'b0;
    waited = 0;
    while (done8 !== 1'b1 && waited < 30) begin
      @(negedge clk); waited++;
    end
    vec++;
    if (done8 !== 1'b1) begin errs++; $display("FAIL back_to_back_drain done=%b want 1", done8); end
    @(negedge clk);
  endtask

  task automatic test_midrun_reset();
    int stray;
    stray = 0;
    x8 = 8'h00;
    @(negedge clk); start8 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk); start8 = 1'b0;
    end
    vec++;
    if (busy8 !== 1'b1 || sen8 !== 1'b1) begin
      errs++;
      $display("FAIL midrun_in_step busy=%b s_en=%b want 1 1", busy8, sen8);
    end
    rst = 1'b0;
    #1;
    vec++;
    if ({busy8, done8, yen8, sen8, ystx8, sadd8, szero8, step8, sel8} !== 11'd0) begin
      errs++;
      $display("FAIL midrun_async_reset got %b want 0", {busy8, done8, yen8, sen8, ystx8, sadd8, szero8, step8, sel8});
    end
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (busy8 || done8) stray++;
    end
    vec++;
    if (stray != 0) begin errs++; $display("FAIL post_reset_idle active cycles %0d want 0", stray); end
    do_run8(8'h00, 8'h01, 2'd1, "post_reset");
  endtask

  task automatic test_iters1();
    int done_at, done_cnt;
    logic [1:0] sel2;
    done_at = -1; done_cnt = 0; sel2 = 2'd0;
    x1 = 8'h01;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); start1 = 1'b0;
      if (done1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (c == 2) sel2 = sel1;
    end
    vec++;
    if (done_at != 4) begin errs++; $display("FAIL iters1_done_cycle got k+%0d want k+4", done_at); end
    vec++;
    if (done_cnt != 1) begin errs++; $display("FAIL iters1_done_count got %0d want 1", done_cnt); end
    vec++;
    if (y1 !== 8'h01) begin errs++; $display("FAIL iters1_final_y got %h want 01", y1); end
    vec++;
    if (s1 !== 3'd1) begin errs++; $display("FAIL iters1_final_s got %0d want 1", s1); end
    vec++;
    if (sel2 !== 2'd2) begin errs++; $display("FAIL iters1_test_sel got %0d want 2", sel2); end
  endtask

  initial begin
    vec = 0; errs = 0;
    test_reset();
    test_runs();
    test_back_to_back();
    test_midrun_reset();
    test_iters1();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
